shift_add_mult: RTL and testbench

- Sequential shift-and-add unsigned multiplier. It is the producer stage directly upstream of the 16-bit datapath register.
- Drives that register's `in` from `product` and its `load` from `load`.
- Accepts one operand pair per start handshake and computes the product over W iterations.
- Emits a single-cycle `load` pulse when the result is valid.

---
 rtl/shift_add_mult_pkg.sv | 20 ++
 rtl/shift_add_mult_ctrl.sv | 81 ++++++++
 rtl/shift_add_mult.sv | 68 ++++++
 tb/tb_shift_add_mult.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   - DEFAULT_W : default operand width (product is 2*DEFAULT_W bits)
//   - state_t   : controller state encoding (binary, two bits)
//   - cnt_width : width of the iteration counter for a given operand width
package shift_add_mult_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A width of at least one bit keeps the counter declarable for tiny W.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Controller for the shift-and-add multiplier: FSM plus iteration counter.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   start - request a new multiplication (honoured only in IDLE)
//   ready - high in IDLE
//   busy  - high in CALC and DONE
//   load  - high for the single DONE cycle (result valid)
//   init  - datapath capture enable on the accepting edge
//   step  - datapath iteration enable, one per CALC cycle
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic load,
  output logic init,
  output logic step
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    init       = 1'b0;
    step       = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          init       = 1'b1;
          cnt_next   = '0;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) begin
          // Park the counter at zero instead of letting it wrap.
          cnt_next   = '0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        load       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier, W iterations per product.
// Feeds a downstream 2W-bit register: product -> its data in, load -> its load.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   start   - request a multiplication (sampled only while ready=1)
//   a, b    - unsigned multiplicand / multiplier, captured on the accepting edge
//   ready   - high in IDLE
//   busy    - high in CALC and DONE
//   load    - one-cycle result-valid strobe
//   product - {acc, mplr}; valid during load, held until the next accept
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           load,
  output logic [2*W-1:0] product
);

  logic         init;
  logic         step;
  logic [W-1:0] mcand;
  logic [W-1:0] acc;
  logic [W-1:0] mplr;
  logic [W:0]   sum;

  shift_add_mult_ctrl #(.W(W)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready),
    .busy  (busy),
    .load  (load),
    .init  (init),
    .step  (step)
  );

  // One extra bit holds the adder carry so it shifts into acc's MSB.
  assign sum = {1'b0, acc} + {1'b0, (mplr[0] ? mcand : '0)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
    end else if (init) begin
      mcand <= a;
      mplr  <= b;
      acc   <= '0;
    end else if (step) begin
      // {acc, mplr} <= {sum, mplr} >> 1: the consumed multiplier bit drops
      // out and the low result bit moves into the freed mplr MSB.
      acc  <= sum[W:1];
      mplr <= {sum[0], mplr[W-1:1]};
    end
  end

  assign product = {acc, mplr};

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ready8, busy8, load8;
  logic [15:0] product8;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        ready4, busy4, load4;
  logic [7:0]  product4;

  shift_add_mult #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .load(load8), .product(product8)
  );

  shift_add_mult #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .load(load4), .product(product4)
  );

  // Downstream 16-bit register fed by the multiplier.
  logic [15:0] dreg;
  always @(posedge clk or negedge rst) begin
    if (!rst) dreg <= '0;
    else if (load8) dreg <= product8;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[$];

  // One W=8 multiplication; lat counts edges after the accept edge until load.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      output int lat, output logic [15:0] prod,
                      output bit single, output logic [15:0] dval,
                      output logic [15:0] held);
    @(negedge clk);
    chk("ready_before", ready8, 1);
    start8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1;
    prod = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (load8) begin
        lat = i;
        prod = product8;
        break;
      end
    end
    @(negedge clk);
    single = !load8;
    dval = dreg;
    held = product8;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    logic [15:0] prod, dval, held;
    bit single;
    int nload;
    bit drop;
    int times[$];
    logic [15:0] prods[$];
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    int idx;

    // Vector table: fixed corner cases then random pairs, expected = a*b.
    vecs.push_back('{8'd13,  8'd11,  16'd143});
    vecs.push_back('{8'hFF,  8'hFF,  16'hFE01});
    vecs.push_back('{8'd0,   8'd200, 16'd0});
    vecs.push_back('{8'd200, 8'd0,   16'd0});
    vecs.push_back('{8'd1,   8'd1,   16'd1});
    vecs.push_back('{8'd255, 8'd1,   16'd255});
    vecs.push_back('{8'd128, 8'd2,   16'd256});
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.a = 8'($urandom);
      v.b = 8'($urandom);
      v.p = 16'(int'(v.a) * int'(v.b));
      vecs.push_back(v);
    end

    // Reset state, with start ignored while in reset.
    #1;
    chk("rst_product", product8, 0);
    chk("rst_load", load8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_ready", ready8, 1);
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
    @(posedge clk); #1;
    chk("rst_start_ignored", ready8, 1);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, lat, prod, single, dval, held);
      $display("vec %0d: %0d * %0d -> %0d (lat %0d)", i, vecs[i].a, vecs[i].b, prod, lat);
      chk("latency", lat, 8);
      chk("product", prod, vecs[i].p);
      chk("load_single", single, 1);
      chk("downstream", dval, vecs[i].p);
      chk("held_idle", held, vecs[i].p);
      chk("ready_after", ready8, 1);
    end

    // Asynchronous reset three cycles into CALC aborts the operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd13; b8 = 8'd11;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy8, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_product", product8, 0);
    chk("abort_load", load8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_ready", ready8, 1);
    @(negedge clk);
    rst = 1'b1;
    nload = 0;
    repeat (20) begin
      @(negedge clk);
      if (load8) nload++;
    end
    $display("abort: loads after release %0d", nload);
    chk("abort_no_load", nload, 0);

    // start pulsed during CALC and DONE must be ignored.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd4;
    @(negedge clk);
    start8 = 1'b0;
    nload = 0; lat = -1; prod = '0; drop = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (drop) begin
        start8 = 1'b0;
        drop = 1'b0;
        chk("ign_ready_after", ready8, 1);
      end
      if (i == 3) begin
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
      end else if (i == 4) begin
        start8 = 1'b0;
      end
      if (load8) begin
        nload++;
        lat = i;
        prod = product8;
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
        drop = 1'b1;
      end
    end
    $display("ignore: loads %0d product %0d lat %0d", nload, prod, lat);
    chk("ign_loads", nload, 1);
    chk("ign_product", prod, 12);
    chk("ign_latency", lat, 8);
    chk("ign_held", product8, 12);

    // Back-to-back with start held high.
    pa[0] = 8'd2;   pb[0] = 8'd3;
    pa[1] = 8'd100; pb[1] = 8'd200;
    pa[2] = 8'd255; pb[2] = 8'd1;
    @(negedge clk);
    a8 = pa[0]; b8 = pb[0]; start8 = 1'b1;
    idx = 1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (load8) begin
        times.push_back(t);
        prods.push_back(product8);
      end
      if (ready8) begin
        if (idx < 3) begin
          a8 = pa[idx]; b8 = pb[idx]; idx++;
        end else begin
          start8 = 1'b0;
        end
      end
    end
    chk("b2b_count", times.size(), 3);
    for (int i = 0; i < 3 && i < prods.size(); i++) begin
      $display("b2b %0d: product %0d at t=%0d", i, prods[i], times[i]);
      chk("b2b_product", prods[i], int'(pa[i]) * int'(pb[i]));
      if (i > 0) chk("b2b_spacing", times[i] - times[i-1], 10);
    end

    // W=4 instance.
    @(negedge clk);
    chk("w4_ready", ready4, 1);
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(negedge clk);
    start4 = 1'b0;
    lat = -1; prod = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (load4) begin
        lat = i;
        prod = 16'(product4);
        break;
      end
    end
    $display("w4: 15 * 15 -> %0d (lat %0d)", prod, lat);
    chk("w4_product", prod, 225);
    chk("w4_latency", lat, 4);
    @(negedge clk);
    chk("w4_single", load4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
